gemv_result_streamer: RTL

- Reads the result side of the GEMV engine.
- When the engine pulses `done`, this block snapshots its parallel `y[0:ROWS-1]` vector into a local buffer, optionally applying ReLU.
- It then streams the buffer out as fixed-width beats over a valid/ready interface to the next layer or the writeback path.
- This frees the engine to start the next GEMV while the results drain.

---
 rtl/gemv_result_streamer.sv | 89 ++++++++
 1 files changed

// File: rtl/gemv_result_streamer.sv
// Captures the GEMV engine's parallel result vector (optional ReLU) and drains it
// as fixed-width valid/ready beats, so the engine can start its next GEMV.
module gemv_result_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 128,
    parameter int unsigned BEAT_ELEMS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            y_in [ROWS],
    input  logic                             y_done,
    input  logic                             relu_en,
    output logic [BEAT_ELEMS*DATA_WIDTH-1:0] m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned NUM_BEATS = (ROWS + BEAT_ELEMS - 1) / BEAT_ELEMS;
    localparam int unsigned IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned BEAT_W    = BEAT_ELEMS * DATA_WIDTH;
    localparam int unsigned BUF_W     = NUM_BEATS * BEAT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  beat_idx_q;
    logic [BUF_W-1:0]  buf_q;
    logic              overrun_q;

    // Buffer is padded to a whole number of beats; pad slots are never written and stay 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_idx_q <= '0;
            buf_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (y_done) begin
                        for (int r = 0; r < int'(ROWS); r++) begin
                            buf_q[r*DATA_WIDTH +: DATA_WIDTH] <=
                                (relu_en && y_in[r][DATA_WIDTH-1]) ? '0 : y_in[r];
                        end
                        beat_idx_q <= '0;
                        state_q    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // A capture request while draining is dropped and flagged.
                    overrun_q <= y_done;
                    if (m_ready) begin
                        if (beat_idx_q == LAST_IDX) begin
                            beat_idx_q <= '0;
                            state_q    <= S_IDLE;
                        end else begin
                            beat_idx_q <= beat_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Beat mux from registered buffer and index only; no path from m_ready.
    always_comb begin
        m_data = '0;
        for (int b = 0; b < int'(NUM_BEATS); b++) begin
            if (beat_idx_q == IDX_W'(b)) begin
                m_data = buf_q[b*BEAT_W +: BEAT_W];
            end
        end
    end

    assign m_valid = (state_q == S_STREAM);
    assign busy    = (state_q == S_STREAM);
    assign m_last  = (state_q == S_STREAM) && (beat_idx_q == LAST_IDX);
    assign overrun = overrun_q;

endmodule
